// File: rtl/wb_queue_stage.sv
// Writeback stage with an in-order retire queue in front of a shared regfile write port.
// Entries retire from the head. Entries with no byte strobes retire without needing the port.
module wb_queue_stage #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned BUS_WD = DATA_W / 8 + ADDR_W + DATA_W + PC_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  ws_allowin,
  input  logic                                  ms_to_ws_valid,
  input  logic [BUS_WD-1:0]                     ms_to_ws_bus,
  input  logic                                  ws_flush,
  input  logic                                  rf_grant,
  output logic [DATA_W/8+ADDR_W+DATA_W-1:0]     ws_to_rf_bus,
  output logic [DEPTH*(2+ADDR_W)-1:0]           ws_hazard_bus,
  output logic [$clog2(DEPTH+1)-1:0]            ws_count,
  output logic [PC_W-1:0]                       debug_wb_pc,
  output logic [DATA_W/8-1:0]                   debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                     debug_wb_rf_wdata
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HazW  = 2 + ADDR_W;

  // Payload storage. It is deliberately not reset; occupancy alone decides validity.
  logic [StrbW-1:0]  r_strb [DEPTH];
  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];

  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;

  logic              w_head_v;
  logic              w_we_any;
  logic              w_pop;
  logic              w_push;
  logic [StrbW-1:0]  w_rf_we;
  logic [ADDR_W-1:0] w_head_dest;
  logic [DATA_W-1:0] w_head_data;
  logic [PC_W-1:0]   w_head_pc;

  logic [PC_W-1:0]   w_in_pc;
  logic [DATA_W-1:0] w_in_data;
  logic [ADDR_W-1:0] w_in_dest;
  logic [StrbW-1:0]  w_in_strb;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_in_pc   = ms_to_ws_bus[PC_W-1:0];
  assign w_in_data = ms_to_ws_bus[PC_W +: DATA_W];
  assign w_in_dest = ms_to_ws_bus[PC_W+DATA_W +: ADDR_W];
  assign w_in_strb = ms_to_ws_bus[PC_W+DATA_W+ADDR_W +: StrbW];

  assign w_head_v = (r_count != '0);
  assign w_we_any = |r_strb[r_head];
  assign w_pop    = w_head_v && (rf_grant || !w_we_any);

  // A retiring head frees a slot in the same cycle, so allowin depends on rf_grant.
  assign ws_allowin = (r_count < CntW'(DEPTH)) || w_pop;
  assign w_push     = ms_to_ws_valid && ws_allowin && !reset;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Reset and flush both beat any push or pop arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || ws_flush) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_d;
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_strb[r_tail] <= w_in_strb;
      r_dest[r_tail] <= w_in_dest;
      r_data[r_tail] <= w_in_data;
      r_pc[r_tail]   <= w_in_pc;
    end
  end

  assign w_rf_we     = w_pop ? r_strb[r_head] : '0;
  assign w_head_dest = w_head_v ? r_dest[r_head] : '0;
  assign w_head_data = w_head_v ? r_data[r_head] : '0;
  assign w_head_pc   = w_head_v ? r_pc[r_head] : '0;

  assign ws_to_rf_bus      = {w_rf_we, w_head_dest, w_head_data};
  assign ws_count          = r_count;
  assign debug_wb_pc       = w_head_pc;
  assign debug_wb_rf_wen   = w_rf_we;
  assign debug_wb_rf_wnum  = w_head_dest;
  assign debug_wb_rf_wdata = w_head_data;

  // Slot g of the hazard bus reports the g-th oldest entry, counted from the head.
  for (genvar g = 0; g < DEPTH; g++) begin : g_haz
    logic [PtrW:0]   w_sum;
    logic [PtrW-1:0] w_idx;
    logic            w_v;

    assign w_sum = {1'b0, r_head} + (PtrW + 1)'(g);
    assign w_idx = (w_sum >= (PtrW + 1)'(DEPTH)) ? PtrW'(w_sum - (PtrW + 1)'(DEPTH))
                                                 : w_sum[PtrW-1:0];
    assign w_v   = CntW'(g) < r_count;

    assign ws_hazard_bus[g*HazW +: HazW] = w_v ? {1'b1, |r_strb[w_idx], r_dest[w_idx]} : '0;
  end

endmodule
